cdc_mmio_fifo: RTL

//  Memory-mapped FIFO bridge between the CPU load/store bus and the USB_CDC byte streams.

---
 rtl/cdc_mmio_fifo_pkg.sv | 32 +++
 rtl/cdc_mmio_fifo_sync_fifo.sv | 56 +++++
 rtl/cdc_mmio_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cdc_mmio_fifo_pkg.sv
// Shared constants for the CPU <-> USB_CDC MMIO FIFO bridge.
// Register indices, register bit positions and reset thresholds.
package cdc_mmio_fifo_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_IRQ_CFG = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int ST_OUT_EMPTY = 0;
    localparam int ST_OUT_FULL  = 1;
    localparam int ST_IN_EMPTY  = 2;
    localparam int ST_IN_FULL   = 3;
    localparam int ST_OVF       = 4;
    localparam int ST_UDF       = 5;
    localparam int ST_OUT_LVL   = 8;
    localparam int ST_IN_LVL    = 16;

    localparam int CFG_OUT_IE  = 0;
    localparam int CFG_IN_IE   = 1;
    localparam int CFG_OUT_THR = 8;
    localparam int CFG_IN_THR  = 16;

    localparam int CTL_FLUSH_OUT = 0;
    localparam int CTL_FLUSH_IN  = 1;
    localparam int CTL_CLR_OVF   = 4;
    localparam int CTL_CLR_UDF   = 5;

    localparam logic [7:0] OUT_THR_RST = 8'd1;
    localparam logic [7:0] IN_THR_RST  = 8'd0;

endpackage

// File: rtl/cdc_mmio_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with one-cycle flush.
// Full/empty are judged before this cycle's pop, so a full FIFO drops pushes.
module sync_fifo
    import cdc_mmio_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    assign level_o = r_wptr - r_rptr;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == (AW+1)'(DEPTH));
    assign w_push  = push_i && !full_o && !flush_i;
    assign w_pop   = pop_i && !empty_o && !flush_i;
    assign data_o  = r_mem[r_rptr[AW-1:0]];

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_push)
            r_mem[r_wptr[AW-1:0]] <= data_i;
    end

    // Pointer update; flush empties the FIFO and discards same-cycle traffic
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

endmodule

// File: rtl/cdc_mmio_fifo.sv
// MMIO FIFO bridge: CPU bus registers over IN (CPU->host) and OUT (host->CPU) FIFOs.
// Define CDC_MMIO_FIFO_ERR_EN for sticky overflow/underflow flags in STATUS.
module cdc_mmio_fifo
    import cdc_mmio_fifo_pkg::*;
#(
    parameter int BUS_W     = 32,
    parameter int DATA_W    = 8,
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              sel_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [1:0]        addr_i,
    input  logic [BUS_W-1:0]  data_i,
    output logic [BUS_W-1:0]  data_o,
    output logic              in_irq_o,
    output logic              out_irq_o,
    output logic [DATA_W-1:0] in_data_o,
    output logic              in_valid_o,
    input  logic              in_ready_i,
    input  logic [DATA_W-1:0] out_data_i,
    input  logic              out_valid_i,
    output logic              out_ready_o
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);

    logic              w_rd, w_wr;
    logic              w_data_rd, w_data_wr, w_cfg_wr, w_ctrl_wr;
    logic              w_out_empty, w_out_full, w_in_empty, w_in_full;
    logic [OAW:0]      w_out_level;
    logic [IAW:0]      w_in_level;
    logic [7:0]        w_out_lvl8, w_in_lvl8;
    logic [DATA_W-1:0] w_out_head;
    logic              w_ovf, w_udf;
    logic [BUS_W-1:0]  w_status, w_rdata;

    logic [BUS_W-1:0]  r_data;
    logic              r_out_ie, r_in_ie;
    logic [7:0]        r_out_thr, r_in_thr;
    logic              r_out_irq, r_in_irq;

    assign w_rd      = sel_i && read_i;
    assign w_wr      = sel_i && write_i && !read_i;
    assign w_data_rd = w_rd && (addr_i == REG_DATA);
    assign w_data_wr = w_wr && (addr_i == REG_DATA);
    assign w_cfg_wr  = w_wr && (addr_i == REG_IRQ_CFG);
    assign w_ctrl_wr = w_wr && (addr_i == REG_CTRL);

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (out_valid_i),
        .pop_i   (w_data_rd),
        .flush_i (w_ctrl_wr && data_i[CTL_FLUSH_OUT]),
        .data_i  (out_data_i),
        .data_o  (w_out_head),
        .empty_o (w_out_empty),
        .full_o  (w_out_full),
        .level_o (w_out_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_data_wr),
        .pop_i   (in_ready_i),
        .flush_i (w_ctrl_wr && data_i[CTL_FLUSH_IN]),
        .data_i  (data_i[DATA_W-1:0]),
        .data_o  (in_data_o),
        .empty_o (w_in_empty),
        .full_o  (w_in_full),
        .level_o (w_in_level)
    );

    assign in_valid_o  = !w_in_empty;
    assign out_ready_o = !w_out_full;
    assign w_out_lvl8  = 8'(w_out_level);
    assign w_in_lvl8   = 8'(w_in_level);
    assign data_o      = r_data;
    assign out_irq_o   = r_out_irq;
    assign in_irq_o    = r_in_irq;

`ifdef CDC_MMIO_FIFO_ERR_EN
    logic r_ovf, r_udf;

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_data_wr && w_in_full)
                r_ovf <= 1'b1;
            else if (w_ctrl_wr && data_i[CTL_CLR_OVF])
                r_ovf <= 1'b0;
            if (w_data_rd && w_out_empty)
                r_udf <= 1'b1;
            else if (w_ctrl_wr && data_i[CTL_CLR_UDF])
                r_udf <= 1'b0;
        end
    end

    assign w_ovf = r_ovf;
    assign w_udf = r_udf;
`else
    assign w_ovf = 1'b0;
    assign w_udf = 1'b0;
`endif

    // STATUS word assembly
    always_comb begin
        w_status                   = '0;
        w_status[ST_OUT_EMPTY]     = w_out_empty;
        w_status[ST_OUT_FULL]      = w_out_full;
        w_status[ST_IN_EMPTY]      = w_in_empty;
        w_status[ST_IN_FULL]       = w_in_full;
        w_status[ST_OVF]           = w_ovf;
        w_status[ST_UDF]           = w_udf;
        w_status[ST_OUT_LVL +: 8]  = w_out_lvl8;
        w_status[ST_IN_LVL +: 8]   = w_in_lvl8;
    end

    // Read-data mux; an empty OUT FIFO reads as zero
    always_comb begin
        w_rdata = '0;
        unique case (addr_i)
            REG_DATA:    w_rdata = w_out_empty ? '0 : BUS_W'(w_out_head);
            REG_STATUS:  w_rdata = w_status;
            REG_IRQ_CFG: begin
                w_rdata[CFG_OUT_IE]        = r_out_ie;
                w_rdata[CFG_IN_IE]         = r_in_ie;
                w_rdata[CFG_OUT_THR +: 8]  = r_out_thr;
                w_rdata[CFG_IN_THR +: 8]   = r_in_thr;
            end
            default:     w_rdata = '0;
        endcase
    end

    // Registered read data, held until the next read
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            r_data <= '0;
        else if (w_rd)
            r_data <= w_rdata;
    end

    // IRQ configuration register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_out_ie  <= 1'b0;
            r_in_ie   <= 1'b0;
            r_out_thr <= OUT_THR_RST;
            r_in_thr  <= IN_THR_RST;
        end else if (w_cfg_wr) begin
            r_out_ie  <= data_i[CFG_OUT_IE];
            r_in_ie   <= data_i[CFG_IN_IE];
            r_out_thr <= data_i[CFG_OUT_THR +: 8];
            r_in_thr  <= data_i[CFG_IN_THR +: 8];
        end
    end

    // Level-threshold interrupts, registered one cycle behind the levels
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_out_irq <= 1'b0;
            r_in_irq  <= 1'b0;
        end else begin
            r_out_irq <= r_out_ie && (w_out_lvl8 >= r_out_thr);
            r_in_irq  <= r_in_ie && (w_in_lvl8 <= r_in_thr);
        end
    end

endmodule
